// File: rtl/conv_3x3_channel_acc_pkg.sv
// rtl/conv_3x3_channel_acc_pkg.sv - shared derivations and saturation limits for conv_3x3_channel_acc
package conv_3x3_channel_acc_pkg;

  typedef enum logic [1:0] {
    PH_FIRST,
    PH_ACC,
    PH_LAST
  } phase_e;

  function automatic int cnt_width_pxl(input int width, input int height);
    return $clog2(width * height);
  endfunction

  function automatic int cnt_width_ch(input int ch_num);
    return $clog2(ch_num) + 1;
  endfunction

  function automatic longint sat_max(input int data_width);
    return (longint'(1) <<< (data_width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int data_width);
    return -(longint'(1) <<< (data_width - 1));
  endfunction

endpackage

// File: rtl/conv_3x3_sat_add.sv
// rtl/conv_3x3_sat_add.sv - combinational signed add clamped to the DATA_WIDTH range
module conv_3x3_sat_add
  import conv_3x3_channel_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum
);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(sat_min(DATA_WIDTH));

  logic [DATA_WIDTH:0] wide;

  assign wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};

  // Top two bits disagree only on overflow; the top bit gives the true sign.
  always_comb begin
    sum = wide[DATA_WIDTH-1:0];
    if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1]) begin
      sum = wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/conv_3x3_channel_acc.sv
// rtl/conv_3x3_channel_acc.sv - sums per-input-channel partial frames; optional CONV_3X3_CHANNEL_ACC_RELU_EN rectifies output
module conv_3x3_channel_acc
  import conv_3x3_channel_acc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int IMAGE_WIDTH    = 64,
  parameter int IMAGE_HEIGHT   = 64,
  parameter int CHANNEL_NUM_IN = 304
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int IMAGE_SIZE    = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CNT_WIDTH_PXL = cnt_width_pxl(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int CNT_WIDTH_CH  = cnt_width_ch(CHANNEL_NUM_IN);
  localparam logic [CNT_WIDTH_PXL-1:0] PXL_LAST = CNT_WIDTH_PXL'(IMAGE_SIZE - 1);
  localparam logic [CNT_WIDTH_CH-1:0]  CH_LAST  = CNT_WIDTH_CH'(CHANNEL_NUM_IN - 1);

  logic [DATA_WIDTH-1:0] mem [IMAGE_SIZE];

  logic [CNT_WIDTH_PXL-1:0] pxl_cnt_q, pxl_cnt_d;
  logic [CNT_WIDTH_CH-1:0]  ch_cnt_q, ch_cnt_d;
  logic [DATA_WIDTH-1:0]    pxl_out_q, pxl_out_d;
  logic                     valid_out_q, valid_out_d;
  logic                     frame_done_q, frame_done_d;

  phase_e                phase;
  logic [DATA_WIDTH-1:0] add_a, sum, out_val;
  logic                  wr_en;

  always_comb begin
    if (ch_cnt_q == CH_LAST)    phase = PH_LAST;
    else if (ch_cnt_q == '0)    phase = PH_FIRST;
    else                        phase = PH_ACC;
  end

  // Channel 0 adds to zero so FIRST stores pxl_in and single-channel LAST passes it through.
  assign add_a = (ch_cnt_q == '0) ? '0 : mem[pxl_cnt_q];

  conv_3x3_sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_sat_add (
    .a   (add_a),
    .b   (pxl_in),
    .sum (sum)
  );

`ifdef CONV_3X3_CHANNEL_ACC_RELU_EN
  assign out_val = sum[DATA_WIDTH-1] ? '0 : sum;
`else
  assign out_val = sum;
`endif

  always_comb begin
    pxl_cnt_d    = pxl_cnt_q;
    ch_cnt_d     = ch_cnt_q;
    pxl_out_d    = pxl_out_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    if (valid_in) begin
      wr_en = (phase != PH_LAST);
      if (phase == PH_LAST) begin
        valid_out_d  = 1'b1;
        pxl_out_d    = out_val;
        frame_done_d = (pxl_cnt_q == PXL_LAST);
      end
      if (pxl_cnt_q == PXL_LAST) begin
        pxl_cnt_d = '0;
        ch_cnt_d  = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + CNT_WIDTH_CH'(1);
      end else begin
        pxl_cnt_d = pxl_cnt_q + CNT_WIDTH_PXL'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pxl_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      pxl_out_q    <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pxl_cnt_q    <= pxl_cnt_d;
      ch_cnt_q     <= ch_cnt_d;
      pxl_out_q    <= pxl_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Buffer is never cleared; channel 0 overwrites every location.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[pxl_cnt_q] <= sum;
    end
  end

  assign pxl_out    = pxl_out_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/conv_3x3_channel_acc.md
Name: conv_3x3_channel_acc

Overview:
- Downstream of the 3x3 convolution top. Consumes its serial per-input-channel partial-result stream (pxl_out/valid_out).
- Sums the CHANNEL_NUM_IN partial frames pixel-by-pixel into an on-chip frame buffer.
- Emits one finished output-channel frame in raster order during the last input channel.
- Repeats for every output channel with no gap or reconfiguration.

Parameters:
- DATA_WIDTH, 32, width of signed two's-complement pixel words in and out.
- IMAGE_WIDTH, 64, frame width in pixels.
- IMAGE_HEIGHT, 64, frame height in pixels.
- CHANNEL_NUM_IN, 304, partial frames summed per output pixel; must be >= 1.
- localparam IMAGE_SIZE = IMAGE_WIDTH*IMAGE_HEIGHT; CNT_WIDTH_PXL = $clog2(IMAGE_SIZE); CNT_WIDTH_CH = $clog2(CHANNEL_NUM_IN)+1.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  pxl_in carries a partial result this cycle.
- pxl_in  input  DATA_WIDTH  partial convolution result, signed.
- pxl_out  output  DATA_WIDTH  accumulated pixel, signed.
- valid_out  output  1  pxl_out valid this cycle.
- frame_done  output  1  one-cycle pulse coincident with the last pixel of an output frame.

Behaviour:
- Reset (synchronous, active-high): pxl_out=0, valid_out=0, frame_done=0, pxl_cnt=0, ch_cnt=0. Frame buffer contents are not cleared; channel 0 overwrites them.
- Frame buffer: IMAGE_SIZE x DATA_WIDTH array, asynchronous read and synchronous write, both addressed by pxl_cnt.
- No backpressure. Every valid_in cycle is accepted. Idle cycles (valid_in=0) hold all state, and valid_out drops to 0.
- Phase is decoded from ch_cnt:
  - FIRST (ch_cnt==0): mem[pxl_cnt] <= pxl_in.
  - ACC (0<ch_cnt<CHANNEL_NUM_IN-1): mem[pxl_cnt] <= sat(mem[pxl_cnt]+pxl_in).
  - LAST (ch_cnt==CHANNEL_NUM_IN-1): pxl_out <= sat(mem[pxl_cnt]+pxl_in), valid_out<=1, no write.
  - If CHANNEL_NUM_IN==1, LAST has priority over FIRST: pass-through pxl_out<=pxl_in.
- Latency: valid_out/pxl_out are registered 1 cycle after the accepted LAST-phase valid_in.
- Saturation: the sum is formed at DATA_WIDTH+1 bits and clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. It never wraps. Saturation in ACC is stored, and later sums start from the clamped value.
- Counters, on each accepted valid_in:
  - pxl_cnt increments. At IMAGE_SIZE-1 it wraps to 0 and ch_cnt increments.
  - When ch_cnt is at CHANNEL_NUM_IN-1 and pxl_cnt wraps, ch_cnt wraps to 0 and the next output channel begins immediately.
  - Back-to-back valid_in across the wrap boundary is legal.
- frame_done: registered high together with valid_out for the pixel accepted at pxl_cnt==IMAGE_SIZE-1 in LAST; otherwise 0.
- Reset mid-frame: partial sums are abandoned and the next valid_in is treated as channel 0, pixel 0. A pending valid_out is squashed.
- valid_in with X data: no protection required; the bench drives clean data only.

Optional Feature:
- Macro: CONV_3X3_CHANNEL_ACC_RELU_EN.
- Defined: in LAST phase, a negative saturated sum is replaced by 0 before registering pxl_out. Latency is unchanged, and frame_done/valid_out timing is identical.
- Undefined: pxl_out carries the signed saturated sum unmodified.
- Stored partial sums are never rectified in either case.

Decomposition:
- Shared param include next to the existing conv_3x3 parameter definitions holds:
  - IMAGE_SIZE, CNT_WIDTH_PXL and CNT_WIDTH_CH derivations.
  - Signed saturation limits, SAT_MAX/SAT_MIN as functions of DATA_WIDTH.
- One sub-module is natural: conv_3x3_sat_add. It is a combinational signed add with clamp: inputs a, b [DATA_WIDTH]; output sum [DATA_WIDTH]. It is reused for both the ACC and LAST paths.
- Frame buffer is inferred inline; no separate RAM wrapper.

Test Plan (DATA_WIDTH=16, IMAGE_WIDTH=4, IMAGE_HEIGHT=4, CHANNEL_NUM_IN=3 unless stated):
- Three frames of pixel value p+1 (p=0..15) continuous -> 16 valid_out of 3*(p+1) in order, first one cycle after the 33rd input, frame_done only on pixel 15 (value 48).
- Same stream with random 0–3 idle cycles between inputs -> identical output values/order, valid_out strictly 1 cycle after each LAST-phase input.
- All inputs 0x7000 -> every output 0x7FFF. All inputs 0x9000 -> every output 0x8000 (0 with CONV_3X3_CHANNEL_ACC_RELU_EN).
- Reset asserted at channel 1, pixel 7, then three clean frames of value 2 -> outputs all 6; no stale sums and no output before the 33rd post-reset input.
- Two output channels back-to-back (96 inputs: value 1, then value 5) -> 16 outputs of 3, then 16 outputs of 15, two frame_done pulses.
- CHANNEL_NUM_IN=1, inputs -3..12 -> pass-through outputs -3..12 at 1-cycle latency; with RELU_EN, -3..-1 output as 0.
